// File: rtl/control.sv
// Top-level sequencing FSM for the DPLL SAT solver: decide / propagate /
// backtrack loop around the BCP core, imply queue, trace stack,
// variable-state table and variable start/end clause table.
module control #(
    parameter int VAR_BITS    = 8,
    parameter int CLAUSE_BITS = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   bcp_busy,
    input  logic                   conflict,
    input  logic [CLAUSE_BITS-1:0] bcp_clause_idx,
    output logic                   reset_bcp,
    input  logic                   empty_imply,
    input  logic [VAR_BITS-1:0]    var_out_imply,
    input  logic                   val_out_imply,
    input  logic                   type_out_imply,
    output logic                   pop_imply,
    input  logic                   empty_trace,
    input  logic [VAR_BITS-1:0]    var_out_trace,
    input  logic                   val_out_trace,
    input  logic                   type_out_trace,
    output logic                   pop_trace,
    output logic                   push_trace,
    output logic [VAR_BITS-1:0]    var_in_trace,
    output logic                   val_in_trace,
    output logic                   type_in_trace,
    output logic                   write_vs,
    output logic [VAR_BITS-1:0]    var_in_vs,
    output logic                   val_in_vs,
    output logic                   unassign_in_vs,
    input  logic [CLAUSE_BITS-1:0] start_clause,
    input  logic [CLAUSE_BITS-1:0] end_clause,
    output logic                   read_var_start_end,
    output logic [VAR_BITS-1:0]    var_in_vse,
    output logic                   sat,
    output logic                   unsat
);

    typedef enum logic [3:0] {
        S_IDLE, S_BCP_WAIT, S_DECIDE, S_ASSIGN, S_BACKTRACK,
        S_FLIP, S_VSE_READ, S_BCP_START, S_SAT, S_UNSAT
    } state_t;

    state_t                 r_state, w_next;
    logic [VAR_BITS-1:0]    r_cur_var;
    logic                   r_cur_val;
    logic                   r_cur_type;
    logic [CLAUSE_BITS-1:0] r_start_clause;
    logic [CLAUSE_BITS-1:0] r_end_clause;

    // Clause index and the latched clause range are kept for status/debug
    // only; fold them into a sink so they stay visible without driving logic.
    logic w_unused;
    assign w_unused = ^{bcp_clause_idx, r_start_clause, r_end_clause};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Latch the variable being assigned/flipped and the clause range
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cur_var      <= '0;
            r_cur_val      <= 1'b0;
            r_cur_type     <= 1'b0;
            r_start_clause <= '0;
            r_end_clause   <= '0;
        end else begin
            if (r_state == S_DECIDE && !empty_imply) begin
                r_cur_var  <= var_out_imply;
                r_cur_val  <= val_out_imply;
                r_cur_type <= type_out_imply;
            end
            // A decision popped during backtrack comes back with the opposite value
            if (r_state == S_BACKTRACK && !empty_trace && !type_out_trace) begin
                r_cur_var <= var_out_trace;
                r_cur_val <= ~val_out_trace;
            end
            if (r_state == S_BCP_START) begin
                r_start_clause <= start_clause;
                r_end_clause   <= end_clause;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (start) w_next = S_BCP_WAIT;
            S_BCP_WAIT:  if (!bcp_busy) w_next = conflict ? S_BACKTRACK : S_DECIDE;
            S_DECIDE:    w_next = empty_imply ? S_SAT : S_ASSIGN;
            S_ASSIGN:    w_next = S_VSE_READ;
            S_BACKTRACK: begin
                if (empty_trace)         w_next = S_UNSAT;
                else if (!type_out_trace) w_next = S_FLIP;
            end
            S_FLIP:      w_next = S_VSE_READ;
            S_VSE_READ:  w_next = S_BCP_START;
            S_BCP_START: w_next = S_BCP_WAIT;
            S_SAT:       w_next = S_SAT;
            S_UNSAT:     w_next = S_UNSAT;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output decode: strobes and data from state plus latched registers
    always_comb begin
        reset_bcp          = 1'b0;
        pop_imply          = 1'b0;
        pop_trace          = 1'b0;
        push_trace         = 1'b0;
        var_in_trace       = '0;
        val_in_trace       = 1'b0;
        type_in_trace      = 1'b0;
        write_vs           = 1'b0;
        var_in_vs          = '0;
        val_in_vs          = 1'b0;
        unassign_in_vs     = 1'b0;
        read_var_start_end = 1'b0;
        var_in_vse         = '0;
        sat                = 1'b0;
        unsat              = 1'b0;
        unique case (r_state)
            S_DECIDE: pop_imply = !empty_imply;
            S_ASSIGN: begin
                write_vs      = 1'b1;
                var_in_vs     = r_cur_var;
                val_in_vs     = r_cur_val;
                push_trace    = 1'b1;
                var_in_trace  = r_cur_var;
                val_in_trace  = r_cur_val;
                type_in_trace = r_cur_type;
            end
            S_BACKTRACK: begin
                if (!empty_trace) begin
                    pop_trace = 1'b1;
                    // Forced entries are undone in place; decisions get flipped
                    if (type_out_trace) begin
                        write_vs       = 1'b1;
                        var_in_vs      = var_out_trace;
                        unassign_in_vs = 1'b1;
                    end
                end
            end
            S_FLIP: begin
                write_vs      = 1'b1;
                var_in_vs     = r_cur_var;
                val_in_vs     = r_cur_val;
                push_trace    = 1'b1;
                var_in_trace  = r_cur_var;
                val_in_trace  = r_cur_val;
                type_in_trace = 1'b1;
            end
            S_VSE_READ: begin
                read_var_start_end = 1'b1;
                var_in_vse         = r_cur_var;
            end
            S_BCP_START: reset_bcp = 1'b1;
            S_SAT:       sat       = 1'b1;
            S_UNSAT:     unsat     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control.sv
// Directed bench for control: expected output snapshots are queued as each
// step is driven and popped/compared when the outputs are sampled.
module tb_control;

    localparam int VB = 8;
    localparam int CB = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0, bcp_busy = 1'b0, conflict = 1'b0;
    logic [CB-1:0] bcp_clause_idx = '0, start_clause = '0, end_clause = '0;
    logic          empty_imply = 1'b1, val_out_imply = 1'b0, type_out_imply = 1'b0;
    logic [VB-1:0] var_out_imply = '0;
    logic          empty_trace = 1'b1, val_out_trace = 1'b0, type_out_trace = 1'b0;
    logic [VB-1:0] var_out_trace = '0;

    logic          reset_bcp, pop_imply, pop_trace, push_trace;
    logic [VB-1:0] var_in_trace, var_in_vs, var_in_vse;
    logic          val_in_trace, type_in_trace, write_vs, val_in_vs, unassign_in_vs;
    logic          read_var_start_end, sat, unsat;

    typedef struct packed {
        logic          reset_bcp;
        logic          pop_imply;
        logic          pop_trace;
        logic          push_trace;
        logic [VB-1:0] var_in_trace;
        logic          val_in_trace;
        logic          type_in_trace;
        logic          write_vs;
        logic [VB-1:0] var_in_vs;
        logic          val_in_vs;
        logic          unassign_in_vs;
        logic          read_var_start_end;
        logic [VB-1:0] var_in_vse;
        logic          sat;
        logic          unsat;
    } out_t;

    out_t q[$];
    out_t e;
    int   checks = 0;
    int   errors = 0;

    control #(.VAR_BITS(VB), .CLAUSE_BITS(CB)) dut (
        .clock(clock), .reset(reset), .start(start), .bcp_busy(bcp_busy),
        .conflict(conflict), .bcp_clause_idx(bcp_clause_idx), .reset_bcp(reset_bcp),
        .empty_imply(empty_imply), .var_out_imply(var_out_imply),
        .val_out_imply(val_out_imply), .type_out_imply(type_out_imply),
        .pop_imply(pop_imply), .empty_trace(empty_trace),
        .var_out_trace(var_out_trace), .val_out_trace(val_out_trace),
        .type_out_trace(type_out_trace), .pop_trace(pop_trace),
        .push_trace(push_trace), .var_in_trace(var_in_trace),
        .val_in_trace(val_in_trace), .type_in_trace(type_in_trace),
        .write_vs(write_vs), .var_in_vs(var_in_vs), .val_in_vs(val_in_vs),
        .unassign_in_vs(unassign_in_vs), .start_clause(start_clause),
        .end_clause(end_clause), .read_var_start_end(read_var_start_end),
        .var_in_vse(var_in_vse), .sat(sat), .unsat(unsat)
    );

    always #5 clock = ~clock;

    function automatic out_t actual();
        out_t a;
        a = '{reset_bcp, pop_imply, pop_trace, push_trace, var_in_trace,
              val_in_trace, type_in_trace, write_vs, var_in_vs, val_in_vs,
              unassign_in_vs, read_var_start_end, var_in_vse, sat, unsat};
        return a;
    endfunction

    // Pop the oldest expectation and compare against the live outputs
    task automatic check(input string tag);
        out_t got, exp;
        #1;
        got = actual();
        exp = q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs already driven for this cycle; queue expectation and check
    task automatic step(input out_t ex, input string tag);
        q.push_back(ex);
        check(tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; start = 1'b0; bcp_busy = 1'b0; conflict = 1'b0;
        empty_imply = 1'b1; empty_trace = 1'b1; type_out_trace = 1'b0;
        step('0, "reset_zero");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [VB-1:0] rv;

        // ---- SAT path ----
        #2;
        step('0, "reset_initial");
        do_reset();
        step('0, "idle_no_start");
        @(negedge clock); start = 1'b1;
        step('0, "idle_start");                         // IDLE
        @(negedge clock); start = 1'b0; bcp_busy = 1'b1; conflict = 1'b1;
        step('0, "wait_busy_conflict_ignored");         // BCP_WAIT
        @(negedge clock); bcp_busy = 1'b0; conflict = 1'b0;
        step('0, "wait_done");                          // BCP_WAIT
        @(negedge clock); empty_imply = 1'b1;
        step('0, "decide_empty");                       // DECIDE
        e = '0; e.sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); start = i[0]; conflict = 1'b1;
            step(e, "sat_held");
        end

        // ---- UNSAT path ----
        do_reset();
        @(negedge clock); start = 1'b1;
        step('0, "idle_start2");
        @(negedge clock); start = 1'b0; bcp_busy = 1'b0; conflict = 1'b1;
        step('0, "wait_conflict");
        @(negedge clock); empty_trace = 1'b1;
        step('0, "backtrack_empty");
        e = '0; e.unsat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); start = 1'b1;
            step(e, "unsat_held");
        end

        // ---- backtrack forced entries, then flip a decision ----
        do_reset();
        @(negedge clock); start = 1'b1;
        step('0, "idle_start3");
        @(negedge clock); start = 1'b0; bcp_busy = 1'b0; conflict = 1'b1;
        step('0, "wait_conflict3");
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            rv = VB'($urandom_range(0, 255));
            empty_trace = 1'b0; type_out_trace = 1'b1; var_out_trace = rv;
            val_out_trace = i[0];
            e = '0; e.pop_trace = 1'b1; e.write_vs = 1'b1;
            e.var_in_vs = rv; e.unassign_in_vs = 1'b1;
            step(e, "bt_forced");
        end
        @(negedge clock);
        type_out_trace = 1'b0; val_out_trace = 1'b1; var_out_trace = 8'd23;
        e = '0; e.pop_trace = 1'b1;
        step(e, "bt_decision");
        @(negedge clock); empty_trace = 1'b1; var_out_trace = 8'd99;
        e = '0; e.write_vs = 1'b1; e.var_in_vs = 8'd23; e.val_in_vs = 1'b0;
        e.push_trace = 1'b1; e.var_in_trace = 8'd23; e.val_in_trace = 1'b0;
        e.type_in_trace = 1'b1;
        step(e, "flip");
        @(negedge clock);
        e = '0; e.read_var_start_end = 1'b1; e.var_in_vse = 8'd23;
        step(e, "vse_read_flip");
        @(negedge clock); start_clause = 10'd17; end_clause = 10'd42;
        e = '0; e.reset_bcp = 1'b1;
        step(e, "bcp_start_flip");
        @(negedge clock); bcp_busy = 1'b1; conflict = 1'b0;
        step('0, "bcp_wait_after_flip");

        // ---- decide from imply queue ----
        @(negedge clock); bcp_busy = 1'b0; conflict = 1'b0;
        step('0, "wait_no_conflict");
        @(negedge clock);
        empty_imply = 1'b0; var_out_imply = 8'd5; val_out_imply = 1'b1; type_out_imply = 1'b0;
        e = '0; e.pop_imply = 1'b1;
        step(e, "decide_pop");
        @(negedge clock); empty_imply = 1'b1; var_out_imply = 8'd77; val_out_imply = 1'b0;
        e = '0; e.write_vs = 1'b1; e.var_in_vs = 8'd5; e.val_in_vs = 1'b1;
        e.push_trace = 1'b1; e.var_in_trace = 8'd5; e.val_in_trace = 1'b1;
        e.type_in_trace = 1'b0;
        step(e, "assign");
        @(negedge clock);
        e = '0; e.read_var_start_end = 1'b1; e.var_in_vse = 8'd5;
        step(e, "vse_read_assign");
        @(negedge clock);
        e = '0; e.reset_bcp = 1'b1;
        step(e, "bcp_start_assign");

        // ---- async reset while backtracking ----
        @(negedge clock); bcp_busy = 1'b0; conflict = 1'b1;
        step('0, "wait_conflict4");
        @(negedge clock);
        bcp_busy = 1'b1; empty_trace = 1'b0; type_out_trace = 1'b1; var_out_trace = 8'd9;
        e = '0; e.pop_trace = 1'b1; e.write_vs = 1'b1; e.var_in_vs = 8'd9; e.unassign_in_vs = 1'b1;
        step(e, "bt_before_reset");
        #1 reset = 1'b0;
        step('0, "async_reset_mid");
        @(negedge clock); reset = 1'b1; start = 1'b0;
        step('0, "idle_after_reset");
        @(negedge clock); start = 1'b1;
        step('0, "idle_restart");
        @(negedge clock); start = 1'b0; bcp_busy = 1'b0; conflict = 1'b0;
        step('0, "wait_after_restart");
        @(negedge clock); empty_imply = 1'b0; var_out_imply = 8'd3;
        e = '0; e.pop_imply = 1'b1;
        step(e, "decide_after_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control.md
Name: control

Overview:
Top-level sequencing FSM for the hardware DPLL SAT solver. It drives the BCP core, the imply queue, the trace (assignment) stack, the variable-state table and the variable start/end clause table. It performs decide/propagate/backtrack cycles and terminates with sat or unsat.

Parameters:
VAR_BITS, default `MAX_VARS_BITS (sysdefs.svh), width of a variable index
CLAUSE_BITS, default `MAX_CLAUSES_BITS (sysdefs.svh), width of a clause index

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  begin solving (sampled in IDLE)
bcp_busy  in  1  BCP core is processing clauses
conflict  in  1  BCP found a conflict; valid when bcp_busy=0
bcp_clause_idx  in  CLAUSE_BITS  current BCP clause; status only, not used by this block
reset_bcp  out  1  one-cycle clear/kick of BCP core and imply queue
empty_imply  in  1  imply queue empty
var_out_imply / val_out_imply / type_out_imply  in  VAR_BITS/1/1  imply queue head (type 1=forced, 0=decision)
pop_imply  out  1  dequeue imply head
empty_trace  in  1  trace stack empty
var_out_trace / val_out_trace / type_out_trace  in  VAR_BITS/1/1  trace stack top
pop_trace  out  1  pop trace top
push_trace  out  1  push var_in_trace/val_in_trace/type_in_trace
var_in_trace / val_in_trace / type_in_trace  out  VAR_BITS/1/1  push data
write_vs  out  1  write variable-state entry
var_in_vs / val_in_vs / unassign_in_vs  out  VAR_BITS/1/1  var-state write data; unassign_in_vs=1 clears the variable
start_clause / end_clause  in  CLAUSE_BITS  clause range returned by the start/end table
read_var_start_end  out  1  read start/end table for var_in_vse
var_in_vse  out  VAR_BITS  start/end table address
sat  out  1  satisfiable, sticky
unsat  out  1  unsatisfiable, sticky

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0 and all latches (cur_var, cur_val, cur_type, start/end copies) 0.
- Outputs are decoded combinationally from the state and the latched registers. Every strobe is a single-cycle pulse per state visit.
- IDLE: start=1 -> BCP_WAIT.
- BCP_WAIT: hold while bcp_busy=1. When bcp_busy=0: conflict=1 -> BACKTRACK; else -> DECIDE.
- DECIDE:
  - empty_imply=1 -> SAT.
  - Else pop_imply=1 and latch cur_var/cur_val/cur_type from the imply head -> ASSIGN.
- ASSIGN:
  - write_vs=1, var_in_vs=cur_var, val_in_vs=cur_val, unassign_in_vs=0.
  - push_trace=1 with the same var/val and type_in_trace=cur_type.
  - -> VSE_READ.
- BACKTRACK, evaluated each cycle:
  - empty_trace=1 -> UNSAT.
  - type_out_trace=1 (forced): pop_trace=1, write_vs=1, var_in_vs=var_out_trace, unassign_in_vs=1; stay in BACKTRACK.
  - type_out_trace=0 (decision): pop_trace=1, latch cur_var=var_out_trace, cur_val=~val_out_trace -> FLIP.
- FLIP:
  - write_vs=1 with var_in_vs=cur_var, val_in_vs=cur_val, unassign_in_vs=0.
  - push_trace=1 with type_in_trace=1 (now forced).
  - -> VSE_READ.
- VSE_READ: read_var_start_end=1, var_in_vse=cur_var -> BCP_START.
- BCP_START: latch start_clause/end_clause, reset_bcp=1 -> BCP_WAIT.
- SAT / UNSAT: terminal states. sat=1 or unsat=1 is held until reset; no other strobes are asserted.
- Boundary rules:
  - conflict is ignored while bcp_busy=1.
  - Empty trace on conflict is the only path to UNSAT.
  - Empty imply queue with no conflict is the only path to SAT.
  - An async reset mid-operation aborts immediately to IDLE.
  - start is ignored outside IDLE.
- One trace/var-state operation per cycle. pop_trace and push_trace are never asserted in the same cycle.

Test Plan:
- Reset then start=1, bcp_busy 1->0, conflict=0, empty_imply=1 -> DECIDE then sat=1 on the next cycle; sat stays 1; pop_imply never asserted.
- Start, bcp_busy 1->0, conflict=1, empty_trace=1 -> BACKTRACK then unsat=1 and held; pop_trace never asserted.
- Conflict with trace top type=1 for 5 cycles (random vars) -> 5 cycles of pop_trace=1, write_vs=1, unassign_in_vs=1, var_in_vs tracking var_out_trace.
- Trace top type=0, val=1, var=23 -> pop_trace=1; next cycle FLIP: write_vs=1 var 23 val 0, push_trace=1 type_in_trace=1. Then read_var_start_end=1 with var_in_vse=23, then reset_bcp=1, then BCP_WAIT.
- Imply head var=5 val=1 type=0 with no conflict -> pop_imply=1, then write_vs/push_trace var 5 val 1 type 0, then read_var_start_end var 5, then reset_bcp.
- Assert reset=0 while in BACKTRACK with bcp_busy=1 -> outputs 0 immediately and the FSM returns to IDLE.
